// File: rtl/park_pkg.sv
// Shared types, sensor-line encodings and the state-to-a/b mapping for the
// parking-lot sensor-pair car emulator.
package park_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        P1   = 3'd1,
        P2   = 3'd2,
        P3   = 3'd3,
        R2   = 3'd4,
        R1   = 3'd5
    } gen_state_t;

    typedef enum logic {
        DIR_ENTER = 1'b0,
        DIR_EXIT  = 1'b1
    } dir_t;

    // Bit 1 is the outer sensor (a), bit 0 the inner sensor (b).
    localparam logic [1:0] AB_NONE = 2'b00;
    localparam logic [1:0] AB_OUT  = 2'b10;
    localparam logic [1:0] AB_BOTH = 2'b11;
    localparam logic [1:0] AB_IN   = 2'b01;

    function automatic logic [1:0] ab_of(input gen_state_t state, input dir_t dir);
        logic [1:0] first_s;
        logic [1:0] last_s;
        first_s = (dir == DIR_ENTER) ? AB_OUT : AB_IN;
        last_s  = (dir == DIR_ENTER) ? AB_IN  : AB_OUT;
        case (state)
            P1, R1:  ab_of = first_s;
            P2, R2:  ab_of = AB_BOTH;
            P3:      ab_of = last_s;
            default: ab_of = AB_NONE;
        endcase
    endfunction

endpackage

// File: rtl/park_dwell_timer.sv
// Loadable per-phase down-counter; expire is high during the last cycle of a phase.
module park_dwell_timer #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [DWELL_W-1:0] value,
    output logic               expire
);

    logic [DWELL_W-1:0] cnt_r;

    // Count register: load wins, otherwise count down and rest at zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r <= {DWELL_W{1'b0}};
        end else if (load) begin
            cnt_r <= value;
        end else if (cnt_r != {DWELL_W{1'b0}}) begin
            cnt_r <= cnt_r - DWELL_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expire = (cnt_r == DWELL_W'(1));

endmodule

// File: rtl/park_sensor_gen.sv
// Car emulator driving the a/b sensor pair through enter/exit/back-out sequences.
// Optional statistics counters are enabled with the PARK_GEN_STATS_EN macro.
module park_sensor_gen
    import park_pkg::*;
#(
    parameter  int DWELL_W  = 8,
    parameter  int CAPACITY = 15,
    localparam int OCC_W    = $clog2(CAPACITY + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    input  logic               req_dir,
    input  logic [DWELL_W-1:0] req_dwell,
    output logic               req_ready,
    input  logic               abort,
    output logic               a,
    output logic               b,
    output logic               busy,
    output logic               done_enter,
    output logic               done_exit,
    output logic               aborted,
    output logic               err,
`ifdef PARK_GEN_STATS_EN
    output logic [15:0]        stat_enter,
    output logic [15:0]        stat_exit,
    output logic [15:0]        stat_abort,
`endif
    output logic [OCC_W-1:0]   occupancy
);

    gen_state_t         state_r, state_nx;
    dir_t               dir_r, dir_nx;
    logic [DWELL_W-1:0] dwell_r, dwell_nx, dwell_eff_s, load_val_s;
    logic               load_s, expire_s, accept_s, reject_s;
    logic               done_enter_s, done_exit_s, aborted_s, err_s;
    logic [OCC_W-1:0]   occ_r, occ_nx;
    logic [1:0]         ab_r;
    logic               req_ready_r, busy_r;
    logic               done_enter_r, done_exit_r, aborted_r, err_r;

    park_dwell_timer #(.DWELL_W(DWELL_W)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (load_s),
        .value  (load_val_s),
        .expire (expire_s)
    );

    assign dwell_eff_s = (req_dwell == {DWELL_W{1'b0}}) ? DWELL_W'(1) : req_dwell;
    assign accept_s    = req_valid & req_ready_r;
    assign reject_s    = (req_dir == DIR_EXIT) ? (occ_r == {OCC_W{1'b0}})
                                               : (occ_r == OCC_W'(CAPACITY));

    // Next-state, timer control, pulse and occupancy decode.
    always_comb begin
        state_nx     = state_r;
        dir_nx       = dir_r;
        dwell_nx     = dwell_r;
        load_s       = 1'b0;
        load_val_s   = dwell_r;
        done_enter_s = 1'b0;
        done_exit_s  = 1'b0;
        aborted_s    = 1'b0;
        err_s        = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s && reject_s) begin
                    err_s = 1'b1;
                end else if (accept_s) begin
                    state_nx   = P1;
                    dir_nx     = dir_t'(req_dir);
                    dwell_nx   = dwell_eff_s;
                    load_s     = 1'b1;
                    load_val_s = dwell_eff_s;
                end else begin
                    state_nx = IDLE;
                end
            end
            P1: begin
                if (abort) begin
                    state_nx  = IDLE;
                    aborted_s = 1'b1;
                end else if (expire_s) begin
                    state_nx = P2;
                    load_s   = 1'b1;
                end else begin
                    state_nx = P1;
                end
            end
            P2: begin
                if (abort) begin
                    state_nx = R1;
                    load_s   = 1'b1;
                end else if (expire_s) begin
                    state_nx = P3;
                    load_s   = 1'b1;
                end else begin
                    state_nx = P2;
                end
            end
            P3: begin
                // Abort takes priority over a completing dwell.
                if (abort) begin
                    state_nx = R2;
                    load_s   = 1'b1;
                end else if (expire_s) begin
                    state_nx     = IDLE;
                    done_enter_s = (dir_r == DIR_ENTER);
                    done_exit_s  = (dir_r == DIR_EXIT);
                end else begin
                    state_nx = P3;
                end
            end
            R2: begin
                if (expire_s) begin
                    state_nx = R1;
                    load_s   = 1'b1;
                end else begin
                    state_nx = R2;
                end
            end
            R1: begin
                if (expire_s) begin
                    state_nx  = IDLE;
                    aborted_s = 1'b1;
                end else begin
                    state_nx = R1;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        if (done_enter_s) begin
            occ_nx = occ_r + OCC_W'(1);
        end else if (done_exit_s) begin
            occ_nx = occ_r - OCC_W'(1);
        end else begin
            occ_nx = occ_r;
        end
    end

    // State and registered outputs, all derived from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE;
            dir_r        <= DIR_ENTER;
            dwell_r      <= {DWELL_W{1'b0}};
            occ_r        <= {OCC_W{1'b0}};
            ab_r         <= AB_NONE;
            req_ready_r  <= 1'b0;
            busy_r       <= 1'b0;
            done_enter_r <= 1'b0;
            done_exit_r  <= 1'b0;
            aborted_r    <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            state_r      <= state_nx;
            dir_r        <= dir_nx;
            dwell_r      <= dwell_nx;
            occ_r        <= occ_nx;
            ab_r         <= ab_of(state_nx, dir_nx);
            req_ready_r  <= (state_nx == IDLE);
            busy_r       <= (state_nx != IDLE);
            done_enter_r <= done_enter_s;
            done_exit_r  <= done_exit_s;
            aborted_r    <= aborted_s;
            err_r        <= err_s;
        end
    end

`ifdef PARK_GEN_STATS_EN
    logic [15:0] stat_enter_r, stat_exit_r, stat_abort_r;

    // Saturating event counters; rejected requests are not counted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_enter_r <= 16'd0;
            stat_exit_r  <= 16'd0;
            stat_abort_r <= 16'd0;
        end else begin
            stat_enter_r <= (done_enter_s && stat_enter_r != 16'hFFFF) ? stat_enter_r + 16'd1 : stat_enter_r;
            stat_exit_r  <= (done_exit_s  && stat_exit_r  != 16'hFFFF) ? stat_exit_r  + 16'd1 : stat_exit_r;
            stat_abort_r <= (aborted_s    && stat_abort_r != 16'hFFFF) ? stat_abort_r + 16'd1 : stat_abort_r;
        end
    end

    assign stat_enter = stat_enter_r;
    assign stat_exit  = stat_exit_r;
    assign stat_abort = stat_abort_r;
`endif

    assign req_ready  = req_ready_r;
    assign a          = ab_r[1];
    assign b          = ab_r[0];
    assign busy       = busy_r;
    assign done_enter = done_enter_r;
    assign done_exit  = done_exit_r;
    assign aborted    = aborted_r;
    assign err        = err_r;
    assign occupancy  = occ_r;

endmodule

// File: tb/tb_park_sensor_gen.sv
// Scoreboard bench for park_sensor_gen: stimulus pushes expected per-cycle
// observations, a negedge monitor pops and compares them.
module tb_park_sensor_gen;

    logic       clk;
    logic       reset;
    logic       req_valid;
    logic       req_dir;
    logic [7:0] req_dwell;
    logic       req_ready;
    logic       abort;
    logic       a, b, busy;
    logic       done_enter, done_exit, aborted, err;
    logic [3:0] occupancy;
`ifdef PARK_GEN_STATS_EN
    logic [15:0] stat_enter, stat_exit, stat_abort;
`endif

    park_sensor_gen dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_dir    (req_dir),
        .req_dwell  (req_dwell),
        .req_ready  (req_ready),
        .abort      (abort),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done_enter (done_enter),
        .done_exit  (done_exit),
        .aborted    (aborted),
        .err        (err),
`ifdef PARK_GEN_STATS_EN
        .stat_enter (stat_enter),
        .stat_exit  (stat_exit),
        .stat_abort (stat_abort),
`endif
        .occupancy  (occupancy)
    );

    typedef struct packed {
        logic [1:0] ab;
        logic       de;
        logic       dx;
        logic       abt;
        logic       er;
        logic [3:0] occ;
    } obs_t;

    obs_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   tmo_cnt = 0;
    int   occ = 0;
    bit   end_req = 1'b0;
    bit   end_ack = 1'b0;
    logic [1:0] prev_ab = 2'b00;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: reset values, a/b legality, scoreboard pops, end-of-run checks.
    initial begin
        obs_t got;
        obs_t exp;
        forever begin
            @(negedge clk);
            if (!reset) begin
                chk("rst_ab", {30'd0, a, b}, 32'd0);
                chk("rst_busy", {31'd0, busy}, 32'd0);
                chk("rst_ready", {31'd0, req_ready}, 32'd0);
                chk("rst_occ", {28'd0, occupancy}, 32'd0);
                chk("rst_pulses", {28'd0, done_enter, done_exit, aborted, err}, 32'd0);
`ifdef PARK_GEN_STATS_EN
                chk("rst_stats", {stat_enter, stat_exit | stat_abort}, 32'd0);
`endif
                prev_ab = 2'b00;
            end else begin
                chk("ab_legal", {31'd0, (({a, b} ^ prev_ab) == 2'b11)}, 32'd0);
                prev_ab = {a, b};
                if (busy || done_enter || done_exit || aborted || err) begin
                    got = '{ab: {a, b}, de: done_enter, dx: done_exit, abt: aborted,
                            er: err, occ: occupancy};
                    if (sb.size() == 0) begin
                        chk("unexpected_out", {22'd0, got}, 32'd0);
                    end else begin
                        exp = sb.pop_front();
                        chk("seq_obs", {22'd0, got}, {22'd0, exp});
                    end
                end
            end
            if (end_req && !end_ack) begin
                chk("sb_drained", sb.size(), 32'd0);
                chk("timeouts", tmo_cnt, 32'd0);
                chk("final_occ", {28'd0, occupancy}, 32'd1);
`ifdef PARK_GEN_STATS_EN
                chk("stat_enter", {16'd0, stat_enter}, 32'd1);
                chk("stat_exit", {16'd0, stat_exit}, 32'd0);
                chk("stat_abort", {16'd0, stat_abort}, 32'd0);
`endif
                end_ack = 1'b1;
            end
        end
    end

    function automatic logic [1:0] pat(input logic dir, input int phase);
        logic [1:0] p;
        case (phase)
            1:       p = dir ? 2'b01 : 2'b10;
            2:       p = 2'b11;
            3:       p = dir ? 2'b10 : 2'b01;
            default: p = 2'b00;
        endcase
        return p;
    endfunction

    task automatic push(input logic [1:0] ab, input logic de, input logic dx,
                        input logic abt, input logic er, input int o, input int n);
        for (int i = 0; i < n; i++) begin
            sb.push_back('{ab: ab, de: de, dx: dx, abt: abt, er: er, occ: 4'(o)});
        end
    endtask

    // Full forward sequence: three phases of D cycles, then the 00 completion cycle.
    task automatic push_seq(input logic dir, input int dwell, input int o);
        int d;
        d = (dwell == 0) ? 1 : dwell;
        for (int ph = 1; ph <= 3; ph++) push(pat(dir, ph), 1'b0, 1'b0, 1'b0, 1'b0, o, d);
        push(2'b00, ~dir, dir, 1'b0, 1'b0, dir ? o - 1 : o + 1, 1);
    endtask

    // Present a request and return 1 time unit after the accepting edge.
    task automatic send(input logic dir, input logic [7:0] dwell, input bit hold);
        int n;
        req_dir   = dir;
        req_dwell = dwell;
        req_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            tmo_cnt++;
            req_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            if (!hold) req_valid = 1'b0;
        end
    endtask

    initial begin
        int n;
        reset     = 1'b0;
        req_valid = 1'b0;
        req_dir   = 1'b0;
        req_dwell = 8'd0;
        abort     = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;

        // Exit on an empty lot is rejected.
        push(2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1);
        send(1'b1, 8'd5, 1'b0);

        // Enter dwell 2, then exit dwell 0 (treated as 1).
        push_seq(1'b0, 2, occ); send(1'b0, 8'd2, 1'b0); occ = 1;
        push_seq(1'b1, 0, occ); send(1'b1, 8'd0, 1'b0); occ = 0;

        // Three back-to-back enters with req_valid held.
        for (int i = 0; i < 3; i++) begin
            push_seq(1'b0, 1, occ);
            occ++;
            send(1'b0, 8'd1, (i < 2));
        end

        // Abort in the first P3 cycle of an enter with dwell 3.
        push(2'b10, 1'b0, 1'b0, 1'b0, 1'b0, occ, 3);
        push(2'b11, 1'b0, 1'b0, 1'b0, 1'b0, occ, 3);
        push(2'b01, 1'b0, 1'b0, 1'b0, 1'b0, occ, 1);
        push(2'b11, 1'b0, 1'b0, 1'b0, 1'b0, occ, 3);
        push(2'b10, 1'b0, 1'b0, 1'b0, 1'b0, occ, 3);
        push(2'b00, 1'b0, 1'b0, 1'b1, 1'b0, occ, 1);
        send(1'b0, 8'd3, 1'b0);
        repeat (6) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;

        // Abort in the first P1 cycle.
        push(2'b10, 1'b0, 1'b0, 1'b0, 1'b0, occ, 1);
        push(2'b00, 1'b0, 1'b0, 1'b1, 1'b0, occ, 1);
        send(1'b0, 8'd3, 1'b0);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;

        // Fill to capacity, then one more enter is rejected.
        while (occ < 15) begin
            push_seq(1'b0, 1, occ);
            occ++;
            send(1'b0, 8'd1, 1'b0);
        end
        push(2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 15, 1);
        send(1'b0, 8'd1, 1'b0);

        // Reset asserted in the second P2 cycle of an exit with dwell 4.
        push(2'b01, 1'b0, 1'b0, 1'b0, 1'b0, occ, 4);
        push(2'b11, 1'b0, 1'b0, 1'b0, 1'b0, occ, 1);
        send(1'b1, 8'd4, 1'b0);
        repeat (5) @(posedge clk);
        #2 reset = 1'b0;
        occ = 0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;

        // A normal enter after reset release.
        push_seq(1'b0, 2, occ); send(1'b0, 8'd2, 1'b0); occ = 1;

        n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        end_req = 1'b1;
        n = 0;
        while (!end_ack && n < 10) begin
            @(posedge clk);
            n++;
        end
        if (!end_ack) begin
            miscompares++;
            $display("FAIL end_handshake: got 0 want 1");
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
